sum_n_requester: RTL and testbench
==================================

Name: sum_n_requester

Overview:
- Initiator side of the sum-of-1..N handshake. Drives N / N-valid into a sum_N-style responder, captures the returned sum on its one-cycle valid pulse, and returns the ack.
- Runs a self-contained sequence of NUM_REQ requests after a start pulse. Used as an on-chip traffic source and result collector for the summation datapath.

Parameters:
- NUM_REQ, 8, number of requests issued per run (1..255)
- N_START, 1, first N issued (1..7)
- TIMEOUT, 16, cycles to wait in WAIT before declaring a timeout (>= 10)
- GAP, 2, idle cycles between ack and the next request (>= 2)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run when in IDLE, ignored otherwise
- N  out  3  operand to responder
- N_valid_out  out  1  one-cycle request strobe
- sum_in  in  5  result from responder
- sum_valid_in  in  1  one-cycle result-valid pulse from responder
- sum_ack  out  1  one-cycle acknowledge to responder
- busy  out  1  high from start accepted until DONE entered
- done  out  1  one-cycle pulse when run completes
- last_sum  out  5  most recently captured sum_in
- req_count  out  8  requests completed this run
- timeout_count  out  8  requests that timed out this run
- err_count  out  8  sum mismatches (see Optional Feature)

Behaviour:
- Reset (reset==0 at clk edge) forces all of the following to 0, regardless of state:
  - outputs N, N_valid_out, sum_ack, busy, done, last_sum and all counters
  - state = IDLE, N register = N_START
- States are IDLE, REQ, WAIT, ACK, GAP, DONE.
- IDLE: on start, clear all counters, load N = N_START, set busy, go to REQ.
- REQ:
  - N_valid_out = 1 for exactly one cycle, with N stable; go to WAIT.
  - N stays stable until the next REQ.
- WAIT:
  - Timeout counter increments each cycle.
  - On sum_valid_in = 1: capture last_sum <= sum_in, go to ACK.
  - If the counter reaches TIMEOUT first: timeout_count++, last_sum unchanged, go to ACK. The responder is still acked.
  - sum_valid_in outside WAIT is ignored.
- ACK:
  - sum_ack = 1 for exactly one cycle; req_count++.
  - If req_count (after increment) == NUM_REQ, go to DONE; else go to GAP.
- GAP: wait GAP cycles so the responder returns to idle, then advance N and go to REQ.
- N sequence: N_START, N_START+1, ..., 7, 1, 2, ...
  - Wraps 7 -> 1. N = 0 is never issued.
- DONE:
  - done = 1 for one cycle, busy = 0, go to IDLE.
  - Counters and last_sum hold until the next start.
- Counters saturate at 255.
- A start pulse while busy is ignored.
- reset low mid-run aborts immediately.
  - No ack is issued; the responder must be reset alongside.
- Expected sum = N*(N+1)/2, at most 28, so it fits in 5 bits; computed in 5 bits, no overflow.

Optional Feature:
- SUM_CHECK_EN defined:
  - On capture in WAIT, compare sum_in with the expected sum for the current N.
  - On mismatch, err_count++ (saturating). Timeouts are not counted as mismatches.
- SUM_CHECK_EN undefined: err_count is tied to 0 and no comparator logic is present.

Decomposition:
- Package sum_n_pkg:
  - state encoding constants
  - N_W = 3, SUM_W = 5, CNT_W = 8
  - function expected_sum(N)
- One sub-module, sum_n_checker: comparator plus saturating err counter. It is instantiated only under SUM_CHECK_EN.

Test Plan:
- Correct responder, N_START=1, NUM_REQ=7:
  - sums 1, 3, 6, 10, 15, 21, 28 captured in order
  - req_count=7, err_count=0, timeout_count=0, done pulses once
- N_START=6, NUM_REQ=3: issued N sequence is 6, 7, 1 (wrap skips 0); last_sum=1.
- Responder model returns 7 for N=3 with SUM_CHECK_EN:
  - err_count=1, ack still issued, run completes
  - Same run without the macro: err_count=0.
- Responder never pulses valid, TIMEOUT=16:
  - each request acked 16 cycles after entering WAIT
  - timeout_count=NUM_REQ, last_sum=0
- reset driven low during WAIT of request 3:
  - next edge: all outputs 0, state IDLE
  - a subsequent start runs cleanly from N_START
- start pulsed again while busy: no effect on sequence or counters; exactly one done per run.

Source files
------------

// File: rtl/sum_n_pkg.sv
// -----------------------------------------------------------------------------
// sum_n_pkg
// Shared definitions for the sum-of-1..N requester and its optional checker.
//   - FSM state encoding (state_t)
//   - Datapath widths: N_W (operand), SUM_W (result), CNT_W (counters)
//   - expected_sum(n): n*(n+1)/2 evaluated entirely in SUM_W bits
//   - next_n(n): operand sequence step, wrapping 7 -> 1 (0 is never issued)
// -----------------------------------------------------------------------------
package sum_n_pkg;

    localparam int N_W   = 3;
    localparam int SUM_W = 5;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACK  = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // n*(n+1) can reach 56 and would overflow SUM_W bits, so halve whichever
    // factor is even before multiplying; the product never exceeds 28.
    function automatic logic [SUM_W-1:0] expected_sum(input logic [N_W-1:0] n);
        logic [SUM_W-1:0] a;
        logic [SUM_W-1:0] b;
        if (n[0]) begin
            a = SUM_W'(n);
            b = (SUM_W'(n) + SUM_W'(1)) >> 1;
        end else begin
            a = SUM_W'(n) >> 1;
            b = SUM_W'(n) + SUM_W'(1);
        end
        return a * b;
    endfunction

    function automatic logic [N_W-1:0] next_n(input logic [N_W-1:0] n);
        return (n == N_W'(7)) ? N_W'(1) : n + N_W'(1);
    endfunction

endpackage

// File: rtl/sum_n_checker.sv
// -----------------------------------------------------------------------------
// sum_n_checker
// Compares each captured responder result against n*(n+1)/2 for the operand
// that was issued, and counts mismatches in a saturating counter.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   i_clear      in   clears the error counter (start of a run)
//   i_capture    in   a result is being captured this cycle
//   i_n          in   operand the result belongs to
//   i_sum        in   result returned by the responder
//   o_err_count  out  number of mismatches this run (saturates at all-ones)
// -----------------------------------------------------------------------------
module sum_n_checker
    import sum_n_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_capture,
    input  logic [N_W-1:0]   i_n,
    input  logic [SUM_W-1:0] i_sum,
    output logic [CNT_W-1:0] o_err_count
);

    logic             w_mismatch;
    logic [CNT_W-1:0] r_err_count;

    assign w_mismatch  = (i_sum != expected_sum(i_n));
    assign o_err_count = r_err_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (i_clear) begin
            r_err_count <= '0;
        end else if (i_capture && w_mismatch && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sum_n_requester.sv
// -----------------------------------------------------------------------------
// sum_n_requester
// Initiator side of the sum-of-1..N handshake. After a start pulse it issues
// NUM_REQ requests (N = N_START, N_START+1, ..., 7, 1, 2, ...), captures each
// returned sum, acknowledges the responder, and pulses done at the end.
//
// Handshake: every strobe is a single-cycle pulse, there is no back-pressure.
// N_valid_out is high for exactly one cycle with N stable (N then holds until
// the next request); sum_valid_in is only honoured in WAIT; sum_ack is high
// for exactly one cycle per request, including requests that timed out.
//
// Build option: define SUM_CHECK_EN to instantiate sum_n_checker and count
// result mismatches in err_count; otherwise err_count is tied to zero.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous active-low reset
//   start          in   one-cycle pulse, begins a run from IDLE
//   N              out  operand to responder
//   N_valid_out    out  one-cycle request strobe
//   sum_in         in   result from responder
//   sum_valid_in   in   one-cycle result-valid pulse
//   sum_ack        out  one-cycle acknowledge
//   busy           out  high from start accepted until DONE
//   done           out  one-cycle run-complete pulse
//   last_sum       out  most recently captured sum_in
//   req_count      out  requests completed this run
//   timeout_count  out  requests that timed out this run
//   err_count      out  result mismatches (SUM_CHECK_EN only)
//   o_dbg_state    out  current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module sum_n_requester
    import sum_n_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int N_START = 1,
    parameter int TIMEOUT = 16,
    parameter int GAP     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [N_W-1:0]   N,
    output logic             N_valid_out,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             sum_valid_in,
    output logic             sum_ack,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] last_sum,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       o_dbg_state
);

    state_t           r_state;
    state_t           w_next_state;
    logic [N_W-1:0]   r_n;          // operand currently in use (resets to N_START)
    logic [N_W-1:0]   r_n_out;      // visible copy of r_n, resets to 0
    logic [SUM_W-1:0] r_last_sum;
    logic [CNT_W-1:0] r_req_count;
    logic [CNT_W-1:0] r_timeout_count;
    logic [15:0]      r_cnt;        // cycles spent in the current state
    logic             w_capture;
    logic             w_timeout;
    logic             w_last_req;
    logic             w_n_valid;
    logic             w_ack;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_err_count;

    assign w_capture  = (r_state == ST_WAIT) && sum_valid_in;
    // A result arriving on the final WAIT cycle wins over the timeout.
    assign w_timeout  = (r_state == ST_WAIT) && !sum_valid_in &&
                        (r_cnt == 16'(TIMEOUT - 1));
    assign w_last_req = ({1'b0, r_req_count} + 9'd1) == 9'(NUM_REQ);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next_state = r_state;
        w_n_valid    = 1'b0;
        w_ack        = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                w_n_valid    = 1'b1;
                w_busy       = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                if (w_capture || w_timeout) begin
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                w_ack        = 1'b1;
                w_busy       = 1'b1;
                w_next_state = w_last_req ? ST_DONE : ST_GAP;
            end
            ST_GAP: begin
                w_busy = 1'b1;
                if (r_cnt == 16'(GAP - 1)) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand, captured result, counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_n             <= N_W'(N_START);
            r_n_out         <= '0;
            r_last_sum      <= '0;
            r_req_count     <= '0;
            r_timeout_count <= '0;
            r_cnt           <= '0;
        end else begin
            // Restart the dwell counter on every state change so WAIT and GAP
            // both measure from their first cycle.
            if (r_state != w_next_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n             <= N_W'(N_START);
                        r_n_out         <= N_W'(N_START);
                        r_last_sum      <= '0;
                        r_req_count     <= '0;
                        r_timeout_count <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_last_sum <= sum_in;
                    end
                    if (w_timeout && (r_timeout_count != '1)) begin
                        r_timeout_count <= r_timeout_count + CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    if (r_req_count != '1) begin
                        r_req_count <= r_req_count + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (w_next_state == ST_REQ) begin
                        r_n     <= next_n(r_n);
                        r_n_out <= next_n(r_n);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUM_CHECK_EN
    sum_n_checker u_checker (
        .clk         (clk),
        .reset       (reset),
        .i_clear     ((r_state == ST_IDLE) && start),
        .i_capture   (w_capture),
        .i_n         (r_n),
        .i_sum       (sum_in),
        .o_err_count (w_err_count)
    );
`else
    assign w_err_count = '0;
`endif

    assign N             = r_n_out;
    assign N_valid_out   = w_n_valid;
    assign sum_ack       = w_ack;
    assign busy          = w_busy;
    assign done          = w_done;
    assign last_sum      = r_last_sum;
    assign req_count     = r_req_count;
    assign timeout_count = r_timeout_count;
    assign err_count     = w_err_count;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sum_n_requester.sv
// -----------------------------------------------------------------------------
// tb_sum_n_requester
// Directed bench for sum_n_requester. Instance u_dut_a (N_START=1, NUM_REQ=7)
// talks to a responder model that can answer correctly, corrupt the N=3
// result, or stay silent. Instance u_dut_b (N_START=6, NUM_REQ=3) exercises
// the 7 -> 1 operand wrap. Expected operands and results are queued when a
// run is launched / a request is seen and compared when the DUT acks.
// -----------------------------------------------------------------------------
module tb_sum_n_requester;
    import sum_n_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    int   cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- DUT A ----------------
    logic       start_a;
    logic [2:0] n_a;
    logic       nv_a;
    logic [4:0] sum_a;
    logic       sv_a;
    logic       ack_a;
    logic       busy_a;
    logic       done_a;
    logic [4:0] last_a;
    logic [7:0] reqc_a;
    logic [7:0] toc_a;
    logic [7:0] errc_a;
    logic [2:0] st_a;

    sum_n_requester #(.NUM_REQ(7), .N_START(1), .TIMEOUT(16), .GAP(2)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .start         (start_a),
        .N             (n_a),
        .N_valid_out   (nv_a),
        .sum_in        (sum_a),
        .sum_valid_in  (sv_a),
        .sum_ack       (ack_a),
        .busy          (busy_a),
        .done          (done_a),
        .last_sum      (last_a),
        .req_count     (reqc_a),
        .timeout_count (toc_a),
        .err_count     (errc_a),
        .o_dbg_state   (st_a)
    );

    // ---------------- DUT B ----------------
    logic       start_b;
    logic [2:0] n_b;
    logic       nv_b;
    logic [4:0] sum_b;
    logic       sv_b;
    logic       ack_b;
    logic       busy_b;
    logic       done_b;
    logic [4:0] last_b;
    logic [7:0] reqc_b;
    logic [7:0] toc_b;
    logic [7:0] errc_b;
    logic [2:0] st_b;

    sum_n_requester #(.NUM_REQ(3), .N_START(6), .TIMEOUT(16), .GAP(2)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .start         (start_b),
        .N             (n_b),
        .N_valid_out   (nv_b),
        .sum_in        (sum_b),
        .sum_valid_in  (sv_b),
        .sum_ack       (ack_b),
        .busy          (busy_b),
        .done          (done_b),
        .last_sum      (last_b),
        .req_count     (reqc_b),
        .timeout_count (toc_b),
        .err_count     (errc_b),
        .o_dbg_state   (st_b)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Triangular numbers written out, independent of the design's arithmetic.
    function automatic logic [4:0] tri_sum(input int n);
        case (n)
            1:       return 5'd1;
            2:       return 5'd3;
            3:       return 5'd6;
            4:       return 5'd10;
            5:       return 5'd15;
            6:       return 5'd21;
            7:       return 5'd28;
            default: return 5'd0;
        endcase
    endfunction

    // 0 = correct responder, 1 = returns 7 for N=3, 2 = never answers
    int resp_mode = 0;

    function automatic logic [4:0] resp_expect(input int n);
        if (resp_mode == 2) return 5'd0;
        if (resp_mode == 1 && n == 3) return 5'd7;
        return tri_sum(n);
    endfunction

    // ---------------- responder models ----------------
    int         pend_a = 0;
    logic [2:0] lat_a;

    always @(negedge clk) begin
        if (!reset) begin
            sv_a   = 1'b0;
            sum_a  = 5'd0;
            pend_a = 0;
        end else begin
            sv_a = 1'b0;
            if (pend_a > 0) begin
                pend_a--;
                if (pend_a == 0) begin
                    sv_a  = 1'b1;
                    sum_a = (resp_mode == 1 && lat_a == 3'd3) ? 5'd7 : tri_sum(int'(lat_a));
                end
            end
            if (nv_a && resp_mode != 2) begin
                pend_a = 2;
                lat_a  = n_a;
            end
        end
    end

    int         pend_b = 0;
    logic [2:0] lat_b;

    always @(negedge clk) begin
        if (!reset) begin
            sv_b   = 1'b0;
            sum_b  = 5'd0;
            pend_b = 0;
        end else begin
            sv_b = 1'b0;
            if (pend_b > 0) begin
                pend_b--;
                if (pend_b == 0) begin
                    sv_b  = 1'b1;
                    sum_b = tri_sum(int'(lat_b));
                end
            end
            if (nv_b) begin
                pend_b = 2;
                lat_b  = n_b;
            end
        end
    end

    // ---------------- scoreboard / monitors ----------------
    int         en_q[$];     // expected operand sequence for DUT A
    logic [4:0] exp_q[$];    // expected last_sum at each DUT A ack
    int         req_cyc_a;
    int         done_cnt_a = 0;
    int         nb_q[$];     // operands observed from DUT B
    int         done_cnt_b = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (nv_a) begin
                req_cyc_a = cyc;
                if (en_q.size() == 0) begin
                    chk("n_unexpected", 32'(en_q.size()), 32'd1);
                end else begin
                    int en;
                    en = en_q.pop_front();
                    chk("n_issue", 32'(n_a), 32'(en));
                    exp_q.push_back(resp_expect(en));
                end
            end
            if (ack_a) begin
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("last_sum_at_ack", 32'(last_a), 32'(exp_q.pop_front()));
                end
                if (resp_mode == 2) begin
                    chk("timeout_latency", 32'(cyc - req_cyc_a), 32'd17);
                end
            end
            if (done_a) done_cnt_a++;
            if (nv_b) nb_q.push_back(int'(n_b));
            if (done_b) done_cnt_b++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic launch_a(input int nstart, input int count);
        int n;
        n = nstart;
        for (int i = 0; i < count; i++) begin
            en_q.push_back(n);
            n = (n == 7) ? 1 : n + 1;
        end
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        int k;
        k = 0;
        while (!done_a && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_a_within_budget", 32'(done_a), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] exp_err;
        int         k;
        int         seen;
        int         dn;

        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_N", 32'(n_a), 32'd0);
        chk("rst_N_valid", 32'(nv_a), 32'd0);
        chk("rst_ack", 32'(ack_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_last_sum", 32'(last_a), 32'd0);
        chk("rst_req_count", 32'(reqc_a), 32'd0);
        chk("rst_timeout_count", 32'(toc_a), 32'd0);
        chk("rst_err_count", 32'(errc_a), 32'd0);
        chk("rst_state", 32'(st_a), 32'(ST_IDLE));
        reset = 1'b1;

        // 1) Correct responder, sums 1..28 in order
        resp_mode = 0;
        launch_a(1, 7);
        chk("busy_after_start", 32'(busy_a), 32'd1);
        wait_done_a(300);
        chk("run1_busy_in_done", 32'(busy_a), 32'd0);
        chk("run1_req_count", 32'(reqc_a), 32'd7);
        chk("run1_timeout_count", 32'(toc_a), 32'd0);
        chk("run1_err_count", 32'(errc_a), 32'd0);
        chk("run1_last_sum", 32'(last_a), 32'd28);
        chk("run1_queue_empty", 32'(exp_q.size() + en_q.size()), 32'd0);
        repeat (10) @(negedge clk);
        chk("run1_done_once", 32'(done_cnt_a), 32'd1);
        chk("run1_hold_req_count", 32'(reqc_a), 32'd7);
        chk("run1_hold_last_sum", 32'(last_a), 32'd28);

        // 2) Wrap: N_START=6, NUM_REQ=3 -> 6, 7, 1
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (!done_b && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_done_within_budget", 32'(done_b), 32'd1);
        chk("wrap_count", 32'(nb_q.size()), 32'd3);
        if (nb_q.size() == 3) begin
            chk("wrap_n0", 32'(nb_q[0]), 32'd6);
            chk("wrap_n1", 32'(nb_q[1]), 32'd7);
            chk("wrap_n2", 32'(nb_q[2]), 32'd1);
        end
        chk("wrap_last_sum", 32'(last_b), 32'd1);
        chk("wrap_req_count", 32'(reqc_b), 32'd3);
        chk("wrap_err_count", 32'(errc_b), 32'd0);
        repeat (3) @(negedge clk);
        chk("wrap_done_once", 32'(done_cnt_b), 32'd1);

        // 3) Responder returns 7 for N=3
        resp_mode = 1;
`ifdef SUM_CHECK_EN
        exp_err = 8'd1;
`else
        exp_err = 8'd0;
`endif
        launch_a(1, 7);
        wait_done_a(300);
        chk("bad_err_count", 32'(errc_a), 32'(exp_err));
        chk("bad_req_count", 32'(reqc_a), 32'd7);
        chk("bad_timeout_count", 32'(toc_a), 32'd0);
        chk("bad_last_sum", 32'(last_a), 32'd28);
        repeat (3) @(negedge clk);
        chk("bad_done_once", 32'(done_cnt_a), 32'd2);

        // 4) Silent responder: every request times out
        resp_mode = 0;
        pulse_reset();
        resp_mode = 2;
        launch_a(1, 7);
        wait_done_a(600);
        chk("to_timeout_count", 32'(toc_a), 32'd7);
        chk("to_req_count", 32'(reqc_a), 32'd7);
        chk("to_last_sum", 32'(last_a), 32'd0);
        chk("to_err_count", 32'(errc_a), 32'd0);
        repeat (3) @(negedge clk);
        chk("to_done_once", 32'(done_cnt_a), 32'd3);

        // 5) Extra start while busy has no effect
        resp_mode = 0;
        launch_a(1, 7);
        repeat (12) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(300);
        chk("busy_start_req_count", 32'(reqc_a), 32'd7);
        chk("busy_start_last_sum", 32'(last_a), 32'd28);
        repeat (40) @(negedge clk);
        chk("busy_start_done_once", 32'(done_cnt_a), 32'd4);
        chk("busy_start_idle", 32'(st_a), 32'(ST_IDLE));
        chk("busy_start_queue_empty", 32'(exp_q.size() + en_q.size()), 32'd0);

        // 6) Reset during WAIT of request 3, then a clean run
        launch_a(1, 7);
        seen = 0;
        k    = 0;
        while (seen < 3 && k < 300) begin
            @(negedge clk);
            if (nv_a) seen++;
            k++;
        end
        chk("abort_third_request_seen", 32'(seen), 32'd3);
        @(negedge clk);
        chk("abort_in_wait", 32'(st_a), 32'(ST_WAIT));
        reset = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'(st_a), 32'(ST_IDLE));
        chk("abort_N", 32'(n_a), 32'd0);
        chk("abort_N_valid", 32'(nv_a), 32'd0);
        chk("abort_ack", 32'(ack_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_done", 32'(done_a), 32'd0);
        chk("abort_last_sum", 32'(last_a), 32'd0);
        chk("abort_req_count", 32'(reqc_a), 32'd0);
        chk("abort_timeout_count", 32'(toc_a), 32'd0);
        exp_q.delete();
        en_q.delete();
        dn = done_cnt_a;
        @(negedge clk);
        reset = 1'b1;
        launch_a(1, 7);
        wait_done_a(300);
        chk("rerun_req_count", 32'(reqc_a), 32'd7);
        chk("rerun_timeout_count", 32'(toc_a), 32'd0);
        chk("rerun_last_sum", 32'(last_a), 32'd28);
        repeat (3) @(negedge clk);
        chk("rerun_done_once", 32'(done_cnt_a - dn), 32'd1);
        chk("rerun_queue_empty", 32'(exp_q.size() + en_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
